// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   ImemReq    : fetch request valid (driven by the fetch stage)
//   ImemAddr   : fetch address, word aligned (driven by the fetch stage)
//   ImemGnt    : request accepted this cycle (driven by memory)
//   ImemRvalid : response word valid; responses return in request order
//   ImemRdata  : response instruction word
// master = fetch stage side, slave = memory side.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemGnt,
    input  ImemRvalid,
    input  ImemRdata
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemGnt,
    output ImemRvalid,
    output ImemRdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end of the pipelined ARM core.
// Holds PCF, issues in-order requests to a variable-latency instruction
// memory, buffers returned words in a DEPTH-entry prefetch queue and drives
// the F/D pipeline register consumed by decode.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   StallF             : suppress new fetch requests
//   StallD             : hold F/D register, do not pop the queue
//   FlushD             : load a bubble into the F/D register
//   BranchTakenE       : redirect to ALUResultE
//   PCSrcW             : redirect to ResultW (wins over BranchTakenE)
//   imem               : instruction-memory bus (master side)
//   InstrD, PCPlus8D   : decode-stage instruction and its PC + 8
//   ValidD             : InstrD holds a real instruction
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               BranchTakenE,
  input  logic        [31:0] ALUResultE,
  input  logic               PCSrcW,
  input  logic        [31:0] ResultW,
  fetch_stage_if.master      imem,
  output logic        [31:0] InstrD,
  output logic        [31:0] PCPlus8D,
  output logic               ValidD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [31:0] pcPlus8(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

  logic [31:0]   pcF;
  logic          epoch;

  // Prefetch queue: returned words with the PC they were fetched from.
  logic [31:0]   instrQ [DEPTH];
  logic [31:0]   pcQ    [DEPTH];
  logic [PW-1:0] qHead;
  logic [PW-1:0] qTail;
  logic [CW-1:0] qCount;

  // In-order tag FIFO, one entry per outstanding request.
  logic          tagQ   [DEPTH];
  logic [31:0]   tagPc  [DEPTH];
  logic [PW-1:0] tHead;
  logic [PW-1:0] tTail;
  logic [CW-1:0] outCnt;

  logic          redirect;
  logic [31:0]   target;
  logic          credit;
  logic          issue;
  logic          rsp;
  logic          epochNext;
  logic          accept;
  logic          fdBubble;
  logic          pop;

  assign redirect = PCSrcW | BranchTakenE;
  // PCSrcW belongs to the older instruction, so its target takes precedence.
  assign target   = PCSrcW ? ResultW : ALUResultE;

  // Queue entries plus in-flight requests never exceed DEPTH, so every
  // response that is kept always finds a free slot.
  assign credit   = ({1'b0, qCount} + {1'b0, outCnt}) < (CW+1)'(DEPTH);

  assign imem.ImemReq  = ~StallF & ~redirect & credit;
  assign imem.ImemAddr = pcF;

  assign issue     = imem.ImemReq & imem.ImemGnt;
  assign rsp       = imem.ImemRvalid & (outCnt != '0);
  assign epochNext = epoch ^ redirect;
  // A word is kept only if it belongs to the current path; anything that
  // returns during a redirect cycle is wrong-path by definition.
  assign accept    = rsp & ~redirect & (tagQ[tHead] == epochNext);

  assign fdBubble  = redirect | FlushD;
  assign pop       = ~fdBubble & ~StallD & (qCount != '0);

  // ---- Fetch control / F/D register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF      <= RESET_PC;
      epoch    <= 1'b0;
      qHead    <= '0;
      qTail    <= '0;
      qCount   <= '0;
      tHead    <= '0;
      tTail    <= '0;
      outCnt   <= '0;
      InstrD   <= 32'h0;
      PCPlus8D <= 32'h0;
      ValidD   <= 1'b0;
    end else begin
      // Outstanding requests keep draining across redirects as stale words.
      if (issue) tTail <= tTail + PW'(1);
      if (rsp)   tHead <= tHead + PW'(1);
      outCnt <= outCnt + CW'(issue) - CW'(rsp);

      if (redirect) begin
        pcF    <= target;
        epoch  <= ~epoch;
        qHead  <= qTail;
        qCount <= '0;
      end else begin
        if (issue)  pcF   <= pcF + 32'd4;
        if (accept) qTail <= qTail + PW'(1);
        if (pop)    qHead <= qHead + PW'(1);
        qCount <= qCount + CW'(accept) - CW'(pop);
      end

      // Bubble keeps PCPlus8D so R15 reads stay stable across bubbles.
      if (fdBubble) begin
        InstrD <= 32'h0;
        ValidD <= 1'b0;
      end else if (!StallD) begin
        if (qCount != '0) begin
          InstrD   <= instrQ[qHead];
          PCPlus8D <= pcPlus8(pcQ[qHead]);
          ValidD   <= 1'b1;
        end else begin
          InstrD <= 32'h0;
          ValidD <= 1'b0;
        end
      end
    end
  end

  // ---- Queue / tag storage ----
  always_ff @(posedge clk) begin
    if (issue) begin
      tagQ[tTail]  <= epoch;
      tagPc[tTail] <= pcF;
    end
    if (accept) begin
      instrQ[qTail] <= imem.ImemRdata;
      pcQ[qTail]    <= tagPc[tHead];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD;

  fetch_stage_if imemIf();

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .BranchTakenE (BranchTakenE),
    .ALUResultE   (ALUResultE),
    .PCSrcW       (PCSrcW),
    .ResultW      (ResultW),
    .imem         (imemIf),
    .InstrD       (InstrD),
    .PCPlus8D     (PCPlus8D),
    .ValidD       (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } memEntry_t;
  typedef struct { int gen; logic [31:0] pc; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } buf_t;
  typedef struct {
    logic sF, sD, fD;
    logic eReq; logic [31:0] eAddr;
    logic eValid; logic [31:0] eInstr; logic [31:0] ePc8;
  } vec_t;

  // Memory environment
  memEntry_t   memQ[$];
  bit          gntRand = 0, latRand = 0, spurEn = 0;
  int          latFixed = 1;
  logic [31:0] key = 32'h0;
  int          cyc = 0;

  // Reference model: requests in flight tagged with a redirect generation,
  // fetched words waiting for decode, and the decode-stage register.
  req_t        mOut[$];
  buf_t        mBuf[$];
  logic [31:0] mPc;
  int          mGen;
  logic [31:0] mInstr, mPc8;
  logic        mValid;

  logic        lastReq;
  logic [31:0] lastAddr;

  int checks = 0, errors = 0;
  vec_t tbl[20];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mOut.delete();
    mBuf.delete();
    mPc    = RESET_PC;
    mGen   = 0;
    mInstr = 32'h0;
    mPc8   = 32'h0;
    mValid = 1'b0;
  endtask

  function automatic bit allCurrent();
    foreach (mOut[i]) if (mOut[i].gen != mGen) return 0;
    return 1;
  endfunction

  // One clock cycle. Called #1 after a rising edge with the hazard inputs
  // already applied; returns #1 after the next rising edge.
  task automatic cycle();
    bit          rvNow, spur, redir, eReq, keep, grantNow;
    logic [31:0] tgt, addrNow;
    req_t        e;
    buf_t        b;
    int          lat;

    rvNow = (memQ.size() > 0) && (memQ[0].due <= cyc);
    spur  = !rvNow && (memQ.size() == 0) && spurEn && ($urandom_range(0, 19) == 0);
    imemIf.ImemRvalid = rvNow || spur;
    imemIf.ImemRdata  = rvNow ? (memQ[0].addr ^ key) : $urandom;
    imemIf.ImemGnt    = gntRand ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    lastReq  = imemIf.ImemReq;
    lastAddr = imemIf.ImemAddr;

    redir = PCSrcW || BranchTakenE;
    tgt   = PCSrcW ? ResultW : ALUResultE;
    eReq  = !StallF && !redir && ((mBuf.size() + mOut.size()) < DEPTH);
    checkBit("ImemReq", lastReq, eReq);
    check32("ImemAddr", lastAddr, mPc);

    keep = 0;
    if (imemIf.ImemRvalid && mOut.size() > 0) begin
      e    = mOut.pop_front();
      keep = (e.gen == mGen) && !redir;
    end
    if (redir || FlushD) begin
      mInstr = 32'h0;
      mValid = 1'b0;
    end else if (!StallD) begin
      if (mBuf.size() > 0) begin
        b      = mBuf.pop_front();
        mInstr = b.instr;
        mPc8   = b.pc + 32'd8;
        mValid = 1'b1;
      end else begin
        mInstr = 32'h0;
        mValid = 1'b0;
      end
    end
    if (keep) mBuf.push_back('{e.pc ^ key, e.pc});
    if (redir) begin
      mBuf.delete();
      mPc = tgt;
      mGen++;
    end else if (eReq && imemIf.ImemGnt) begin
      mOut.push_back('{mGen, mPc});
      mPc = mPc + 32'd4;
    end

    grantNow = imemIf.ImemReq && imemIf.ImemGnt;
    addrNow  = imemIf.ImemAddr;
    @(posedge clk);
    #1;
    if (rvNow) void'(memQ.pop_front());
    lat = latRand ? $urandom_range(1, 4) : latFixed;
    if (grantNow) memQ.push_back('{addrNow, cyc + lat});
    cyc++;

    checkBit("ValidD", ValidD, mValid);
    check32("InstrD", InstrD, mInstr);
    check32("PCPlus8D", PCPlus8D, mPc8);
  endtask

  task automatic clearInputs();
    StallF = 0; StallD = 0; FlushD = 0;
    BranchTakenE = 0; PCSrcW = 0;
    ALUResultE = 32'h0; ResultW = 32'h0;
  endtask

  task automatic setV(input int i, input bit sF, input bit sD, input bit fD,
                      input bit eReq, input int eAddr, input bit eValid,
                      input int eInstr, input int ePc8);
    tbl[i].sF = sF; tbl[i].sD = sD; tbl[i].fD = fD;
    tbl[i].eReq = eReq; tbl[i].eAddr = eAddr;
    tbl[i].eValid = eValid; tbl[i].eInstr = eInstr; tbl[i].ePc8 = ePc8;
  endtask

  // Runs cycles until the model has `n` requests in flight.
  task automatic waitOutstanding(input int n, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      if (mOut.size() == n) begin ok = 1; break; end
      cycle();
    end
    checkBit(name, ok, 1'b1);
  endtask

  // Runs cycles until ValidD rises; InstrD must stay a bubble meanwhile.
  task automatic waitValid(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (ValidD === 1'b1) begin ok = 1; break; end
      check32({name, "Bubble"}, InstrD, 32'h0);
    end
    checkBit({name, "Timeout"}, ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Cycle i of the straight-line run after reset: 1-cycle memory, Rdata=addr.
    // Expected F/D values are those visible after the edge closing cycle i.
    setV( 0, 0,0,0, 1, 0, 0, 0, 0);
    setV( 1, 0,0,0, 1, 4, 0, 0, 0);
    setV( 2, 0,0,0, 1, 8, 1, 0, 8);
    setV( 3, 0,0,0, 1,12, 1, 4,12);
    setV( 4, 0,0,0, 1,16, 1, 8,16);
    setV( 5, 0,1,0, 1,20, 1, 8,16);
    setV( 6, 0,1,0, 1,24, 1, 8,16);
    setV( 7, 0,1,0, 0,28, 1, 8,16);
    setV( 8, 0,1,0, 0,28, 1, 8,16);
    setV( 9, 0,1,0, 0,28, 1, 8,16);
    setV(10, 0,0,0, 0,28, 1,12,20);
    setV(11, 0,0,0, 1,28, 1,16,24);
    setV(12, 0,0,0, 1,32, 1,20,28);
    setV(13, 0,0,0, 1,36, 1,24,32);
    setV(14, 0,0,0, 1,40, 1,28,36);
    setV(15, 0,0,0, 1,44, 1,32,40);
    setV(16, 0,0,1, 1,48, 0, 0,40);
    setV(17, 0,0,0, 0,52, 1,36,44);
    setV(18, 0,0,0, 1,52, 1,40,48);
    setV(19, 0,0,0, 1,56, 1,44,52);

    clearInputs();
    imemIf.ImemGnt = 1'b1; imemIf.ImemRvalid = 1'b0; imemIf.ImemRdata = 32'h0;
    reset = 1'b1;
    #1;
    checkBit("resetValidD", ValidD, 1'b0);
    check32("resetInstrD", InstrD, 32'h0);
    check32("resetPCPlus8D", PCPlus8D, 32'h0);
    check32("resetImemAddr", imemIf.ImemAddr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    memQ.delete();
    cyc = 0;

    // Straight-line fetch, StallD hold, FlushD bubble.
    for (int i = 0; i < 20; i++) begin
      StallF = tbl[i].sF; StallD = tbl[i].sD; FlushD = tbl[i].fD;
      cycle();
      checkBit($sformatf("tblReq[%0d]", i), lastReq, tbl[i].eReq);
      check32($sformatf("tblAddr[%0d]", i), lastAddr, tbl[i].eAddr);
      checkBit($sformatf("tblValid[%0d]", i), ValidD, tbl[i].eValid);
      check32($sformatf("tblInstr[%0d]", i), InstrD, tbl[i].eInstr);
      check32($sformatf("tblPc8[%0d]", i), PCPlus8D, tbl[i].ePc8);
    end
    clearInputs();

    // Taken branch with two requests in flight.
    latFixed = 3;
    waitOutstanding(2, "branchSetup");
    BranchTakenE = 1'b1; ALUResultE = 32'h100;
    cycle();
    clearInputs();
    checkBit("branchReqLow", lastReq, 1'b0);
    check32("branchAddr", imemIf.ImemAddr, 32'h100);
    checkBit("branchBubble", ValidD, 1'b0);
    waitValid("branch");
    check32("branchFirstPc8", PCPlus8D, 32'h108);
    check32("branchFirstInstr", InstrD, 32'h100 ^ key);

    // PCSrcW and BranchTakenE together: the Writeback target wins.
    PCSrcW = 1'b1; ResultW = 32'h200;
    BranchTakenE = 1'b1; ALUResultE = 32'h100;
    cycle();
    clearInputs();
    check32("dualAddr", imemIf.ImemAddr, 32'h200);
    waitValid("dual");
    check32("dualFirstPc8", PCPlus8D, 32'h208);

    // Reset with two requests outstanding.
    waitOutstanding(2, "resetSetup");
    reset = 1'b1;
    #1;
    checkBit("midResetValidD", ValidD, 1'b0);
    check32("midResetInstrD", InstrD, 32'h0);
    check32("midResetPCPlus8D", PCPlus8D, 32'h0);
    check32("midResetImemAddr", imemIf.ImemAddr, RESET_PC);
    memQ.delete();
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    latFixed = 1;
    check32("postResetAddr", imemIf.ImemAddr, RESET_PC);
    repeat (3) cycle();
    checkBit("firstValidLatency", ValidD, 1'b1);
    check32("firstValidInstr", InstrD, RESET_PC ^ key);
    check32("firstValidPc8", PCPlus8D, RESET_PC + 32'd8);

    // Random latency, grants, hazards and redirects.
    key = 32'h5A5A_A5A5;
    gntRand = 1; latRand = 1; spurEn = 1;
    for (int i = 0; i < 800; i++) begin
      StallF = ($urandom_range(0, 4) == 0);
      StallD = ($urandom_range(0, 4) == 0);
      FlushD = ($urandom_range(0, 9) == 0);
      BranchTakenE = 1'b0; PCSrcW = 1'b0;
      ALUResultE = $urandom & 32'hFFFF_FFFC;
      ResultW    = $urandom & 32'hFFFF_FFFC;
      // Redirect only once earlier wrong-path requests have drained, so the
      // one-bit path tag can never alias an old path.
      if (allCurrent() && ($urandom_range(0, 15) == 0)) begin
        case ($urandom_range(0, 2))
          0:       BranchTakenE = 1'b1;
          1:       PCSrcW = 1'b1;
          default: begin BranchTakenE = 1'b1; PCSrcW = 1'b1; end
        endcase
      end
      cycle();
    end
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
